// File: rtl/operand_stack_if.sv
// Handshake bundle between the CPU controller/datapath (master) and the operand stack (slave).
// The parameters must match the operand_stack instance that uses this interface.
interface operand_stack_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
);
    localparam int CW = $clog2(DEPTH + 1);

    logic             push;
    logic             pop;
    logic             tos;
    logic             err_clr;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] dout;
    logic             stack_empty;
    logic             stack_full;
    logic [CW-1:0]    count;
    logic             overflow;
    logic             underflow;

    modport master (
        output push, pop, tos, err_clr, din,
        input  dout, stack_empty, stack_full, count, overflow, underflow
    );

    modport slave (
        input  push, pop, tos, err_clr, din,
        output dout, stack_empty, stack_full, count, overflow, underflow
    );
endinterface

// File: rtl/operand_stack.sv
// LIFO operand stack with replace/pass-through, registered dout and sticky overflow/underflow.
// Occupancy doubles as the stack pointer; entries never wrap.
module operand_stack #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    operand_stack_if.slave   bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [3:0] {
        OP_NONE,
        OP_REPLACE,
        OP_PASS,
        OP_POP,
        OP_POP_ERR,
        OP_PUSH,
        OP_PUSH_ERR,
        OP_TOS,
        OP_TOS_ERR
    } op_e;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [CW-1:0]    count_q;
    logic [WIDTH-1:0] dout_q;
    logic             overflow_q;
    logic             underflow_q;

    op_e              op;
    logic             is_empty;
    logic             is_full;
    logic [AW-1:0]    top_idx;
    logic [AW-1:0]    push_idx;
    logic [WIDTH-1:0] top_data;
    logic             ovf_evt;
    logic             unf_evt;

    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == CW'(DEPTH));
    assign top_idx  = AW'(count_q - 1'b1);
    assign push_idx = AW'(count_q);
    assign top_data = mem[top_idx];

    // NOTE: every signal gets a default before the decode so no path leaves it unassigned (no latch).
    always_comb begin
        op = OP_NONE;
        if (bus.push && bus.pop)
            op = is_empty ? OP_PASS : OP_REPLACE;
        else if (bus.pop)
            op = is_empty ? OP_POP_ERR : OP_POP;
        else if (bus.push)
            op = is_full ? OP_PUSH_ERR : OP_PUSH;
        else if (bus.tos)
            op = is_empty ? OP_TOS_ERR : OP_TOS;
    end

    assign ovf_evt = (op == OP_PUSH_ERR);
    assign unf_evt = (op == OP_POP_ERR) || (op == OP_TOS_ERR);

    // NOTE: the storage array has no reset; count gates every read, so stale contents are never visible.
    always_ff @(posedge clk) begin
        if (op == OP_REPLACE)
            mem[top_idx] <= bus.din;
        else if (op == OP_PUSH)
            mem[push_idx] <= bus.din;
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q     <= '0;
            dout_q      <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            unique case (op)
                OP_REPLACE: dout_q <= top_data;
                OP_PASS:    dout_q <= bus.din;
                OP_POP: begin
                    dout_q  <= top_data;
                    count_q <= count_q - 1'b1;
                end
                OP_PUSH:    count_q <= count_q + 1'b1;
                OP_TOS:     dout_q <= top_data;
                default:    ;
            endcase
            // An error event in the same cycle as err_clr keeps the flag set.
            overflow_q  <= (overflow_q  && !bus.err_clr) || ovf_evt;
            underflow_q <= (underflow_q && !bus.err_clr) || unf_evt;
        end
    end

    assign bus.dout        = dout_q;
    assign bus.count       = count_q;
    assign bus.stack_empty = is_empty;
    assign bus.stack_full  = is_full;
    assign bus.overflow    = overflow_q;
    assign bus.underflow   = underflow_q;
endmodule

// File: tb/tb_operand_stack.sv
// Directed bench for operand_stack: a queue-based LIFO model is compared every cycle,
// and literal expectations taken from the intended usage pin the model itself.
module tb_operand_stack;
    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH + 1);

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    operand_stack_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    operand_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests  = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a plain queue whose back is the top of stack.
    logic [WIDTH-1:0] q [$];
    logic [WIDTH-1:0] m_dout;
    logic             m_ovf;
    logic             m_unf;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            q.delete();
            m_dout = '0;
            m_ovf  = 1'b0;
            m_unf  = 1'b0;
        end else begin
            logic ov, un;
            ov = 1'b0;
            un = 1'b0;
            if (bus.push && bus.pop) begin
                if (q.size() > 0) begin
                    m_dout = q[q.size()-1];
                    q[q.size()-1] = bus.din;
                end else begin
                    m_dout = bus.din;
                end
            end else if (bus.pop) begin
                if (q.size() > 0) m_dout = q.pop_back();
                else un = 1'b1;
            end else if (bus.push) begin
                if (q.size() < DEPTH) q.push_back(bus.din);
                else ov = 1'b1;
            end else if (bus.tos) begin
                if (q.size() > 0) m_dout = q[q.size()-1];
                else un = 1'b1;
            end
            if (bus.err_clr) begin
                m_ovf = 1'b0;
                m_unf = 1'b0;
            end
            if (ov) m_ovf = 1'b1;
            if (un) m_unf = 1'b1;
        end
    end

    logic chk_en = 1'b0;

    always @(negedge clk) begin
        if (chk_en && rst) begin
            check("mdl_dout",  32'(bus.dout),        32'(m_dout));
            check("mdl_count", 32'(bus.count),       32'(q.size()));
            check("mdl_empty", 32'(bus.stack_empty), 32'(q.size() == 0));
            check("mdl_full",  32'(bus.stack_full),  32'(q.size() == DEPTH));
            check("mdl_ovf",   32'(bus.overflow),    32'(m_ovf));
            check("mdl_unf",   32'(bus.underflow),   32'(m_unf));
        end
    end

    // Drive one cycle of strobes (called just after a falling edge), return after the next falling edge.
    task automatic cyc(input logic pu, input logic po, input logic t,
                       input logic [WIDTH-1:0] d, input logic ec);
        bus.push    = pu;
        bus.pop     = po;
        bus.tos     = t;
        bus.din     = d;
        bus.err_clr = ec;
        @(negedge clk);
        #1;
        bus.push    = 1'b0;
        bus.pop     = 1'b0;
        bus.tos     = 1'b0;
        bus.din     = '0;
        bus.err_clr = 1'b0;
    endtask

    task automatic push_v(input logic [WIDTH-1:0] d); cyc(1'b1, 1'b0, 1'b0, d, 1'b0); endtask
    task automatic pop_c();  cyc(1'b0, 1'b1, 1'b0, '0, 1'b0); endtask
    task automatic tos_c();  cyc(1'b0, 1'b0, 1'b1, '0, 1'b0); endtask
    task automatic clr_c();  cyc(1'b0, 1'b0, 1'b0, '0, 1'b1); endtask

    initial begin
        bus.push = 1'b0; bus.pop = 1'b0; bus.tos = 1'b0;
        bus.din = '0;    bus.err_clr = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_count", 32'(bus.count),       32'd0);
        check("rst_empty", 32'(bus.stack_empty), 32'd1);
        check("rst_full",  32'(bus.stack_full),  32'd0);
        check("rst_dout",  32'(bus.dout),        32'd0);
        check("rst_ovf",   32'(bus.overflow),    32'd0);
        check("rst_unf",   32'(bus.underflow),   32'd0);
        rst = 1'b1;
        chk_en = 1'b1;

        // Basic LIFO ordering
        push_v(8'h11); push_v(8'h22); push_v(8'h33);
        check("t1_count", 32'(bus.count), 32'd3);
        check("t1_empty", 32'(bus.stack_empty), 32'd0);
        pop_c(); check("t1_pop0", 32'(bus.dout), 32'h33);
        pop_c(); check("t1_pop1", 32'(bus.dout), 32'h22);
        pop_c(); check("t1_pop2", 32'(bus.dout), 32'h11);
        check("t1_empty_end", 32'(bus.stack_empty), 32'd1);

        // Fill to DEPTH, then overflow
        for (int i = 1; i <= DEPTH; i++) push_v(WIDTH'(i));
        push_v(8'hAA);
        check("t2_full",  32'(bus.stack_full), 32'd1);
        check("t2_ovf",   32'(bus.overflow),   32'd1);
        check("t2_count", 32'(bus.count),      32'd16);
        pop_c(); check("t2_pop", 32'(bus.dout), 32'd16);
        for (int i = 1; i < DEPTH; i++) pop_c();
        check("t2_drain_dout", 32'(bus.dout), 32'd1);
        clr_c(); check("t2_ovf_clr", 32'(bus.overflow), 32'd0);

        // Underflow on empty, clear, re-trigger via tos, same-cycle clear vs event
        pop_c();
        check("t3_unf",  32'(bus.underflow), 32'd1);
        check("t3_dout", 32'(bus.dout),      32'd1);
        clr_c(); check("t3_unf_clr", 32'(bus.underflow), 32'd0);
        tos_c(); check("t3_tos_unf", 32'(bus.underflow), 32'd1);
        cyc(1'b0, 1'b1, 1'b0, '0, 1'b1);
        check("t3_evt_wins", 32'(bus.underflow), 32'd1);
        clr_c();

        // Replace and pass-through
        push_v(8'h05);
        cyc(1'b1, 1'b1, 1'b0, 8'h09, 1'b0);
        check("t4_rep_dout",  32'(bus.dout),  32'h05);
        check("t4_rep_count", 32'(bus.count), 32'd1);
        tos_c(); check("t4_tos", 32'(bus.dout), 32'h09);
        pop_c();
        cyc(1'b1, 1'b1, 1'b0, 8'h3C, 1'b0);
        check("t4_pass_dout",  32'(bus.dout),      32'h3C);
        check("t4_pass_count", 32'(bus.count),     32'd0);
        check("t4_pass_unf",   32'(bus.underflow), 32'd0);

        // Peek, and tos combined with pop or push
        push_v(8'h40); push_v(8'h41);
        tos_c();
        check("t5_tos_dout",  32'(bus.dout),  32'h41);
        check("t5_tos_count", 32'(bus.count), 32'd2);
        cyc(1'b0, 1'b1, 1'b1, '0, 1'b0);
        check("t5_tp_dout",  32'(bus.dout),  32'h41);
        check("t5_tp_count", 32'(bus.count), 32'd1);
        cyc(1'b1, 1'b0, 1'b1, 8'h55, 1'b0);
        check("t5_tpush_count", 32'(bus.count), 32'd2);
        check("t5_tpush_dout",  32'(bus.dout),  32'h41);
        pop_c(); check("t5_tpush_pop", 32'(bus.dout), 32'h55);

        // Asynchronous reset in the middle of a push burst
        pop_c();
        for (int i = 0; i < 5; i++) push_v(8'h60 + 8'(i));
        check("t6_pre_count", 32'(bus.count), 32'd5);
        bus.push = 1'b1;
        bus.din  = 8'h66;
        #2;
        rst = 1'b0;
        #1;
        check("t6_rst_count", 32'(bus.count),       32'd0);
        check("t6_rst_empty", 32'(bus.stack_empty), 32'd1);
        check("t6_rst_dout",  32'(bus.dout),        32'd0);
        @(negedge clk);
        #1;
        bus.push = 1'b0;
        bus.din  = '0;
        check("t6_hold_count", 32'(bus.count), 32'd0);
        rst = 1'b1;
        push_v(8'h7E);
        check("t6_after_count", 32'(bus.count), 32'd1);
        pop_c(); check("t6_after_dout", 32'(bus.dout), 32'h7E);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end
endmodule
